// File: rtl/matrix_alu_pkg.sv
// Shared constants for the sequential matrix ALU: op codes, FSM states, LED fields.
package matrix_alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
    localparam logic [OP_W-1:0] OP_HAD   = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL   = 3'd3;
    localparam logic [OP_W-1:0] OP_TRN   = 3'd4;
    localparam logic [OP_W-1:0] OP_SCALE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned LED_W      = 16;
    localparam int unsigned LED_BUSY   = 15;
    localparam int unsigned LED_ERR    = 14;
    localparam int unsigned LED_OP_LSB = 11;
    localparam int unsigned LED_C_MSB  = 7;

    // Op codes 6 and 7 are unassigned
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_SCALE;
    endfunction

endpackage

// File: rtl/matrix_alu_mac.sv
// Single multiply-accumulate step; the sum wraps modulo 2^W.
module matrix_alu_mac #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc_in,
    input  logic         clear,
    output logic [W-1:0] acc_out
);

    logic [W-1:0] prod_c;

    // Low W bits of the product are identical for signed and unsigned operands
    assign prod_c  = a * b;
    assign acc_out = (clear ? '0 : acc_in) + prod_c;

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential NxN matrix ALU with three register banks and a one-element-per-cycle datapath.
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned W  = 32,
    parameter int unsigned AW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic            we,
    input  logic            wbank,
    input  logic [AW-1:0]   row,
    input  logic [AW-1:0]   col,
    input  logic [W-1:0]    eleIn,
    input  logic [1:0]      rbank,
    output logic [W-1:0]    eleOut,
    output logic            busy,
    output logic            done,
    output logic [LED_W-1:0] LED
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [W-1:0]    acc_q, scal_q, eleout_q;
    logic [OP_W-1:0] op_q;
    logic            err_q, busy_q, done_q;
    logic [7:0]      lastc_q;
    logic [W-1:0]    a_q [N][N];
    logic [W-1:0]    b_q [N][N];
    logic [W-1:0]    c_q [N][N];

    logic            accept_c, illegal_c, c_wr_c, rng_c;
    logic [W-1:0]    c_val_c, mac_out_c, rd_c;
    logic [LED_W-1:0] led_c;

    // Next-state and element sequencing: MUL walks k innermost, others one element per cycle
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        accept_c  = 1'b0;
        illegal_c = 1'b0;
        c_wr_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    if (op_legal(op)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d   = ST_DONE;
                        illegal_c = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (op_q == OP_MUL) begin
                    k_d = AW'(k_q + 1'b1);
                    if (k_q == LAST) begin
                        k_d    = '0;
                        c_wr_c = 1'b1;
                    end
                end else begin
                    c_wr_c = 1'b1;
                end
                if (c_wr_c) begin
                    j_d = AW'(j_q + 1'b1);
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = AW'(i_q + 1'b1);
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    matrix_alu_mac #(.W(W)) u_mac (
        .a       (a_q[i_q][k_q]),
        .b       (b_q[k_q][j_q]),
        .acc_in  (acc_q),
        .clear   (k_q == '0),
        .acc_out (mac_out_c)
    );

    // Result for the C element addressed by (i, j)
    always_comb begin
        c_val_c = '0;
        case (op_q)
            OP_ADD:   c_val_c = a_q[i_q][j_q] + b_q[i_q][j_q];
            OP_SUB:   c_val_c = a_q[i_q][j_q] - b_q[i_q][j_q];
            OP_HAD:   c_val_c = a_q[i_q][j_q] * b_q[i_q][j_q];
            OP_MUL:   c_val_c = mac_out_c;
            OP_TRN:   c_val_c = a_q[j_q][i_q];
            OP_SCALE: c_val_c = scal_q * a_q[i_q][j_q];
            default:  c_val_c = '0;
        endcase
    end

    // Host read mux; reserved bank and out-of-range indices read as zero
    always_comb begin
        rng_c = (32'(row) < N) && (32'(col) < N);
        rd_c  = '0;
        if (rng_c) begin
            case (rbank)
                2'd0:    rd_c = a_q[row][col];
                2'd1:    rd_c = b_q[row][col];
                2'd2:    rd_c = c_q[row][col];
                default: rd_c = '0;
            endcase
        end
    end

    // FSM state, element counters and the status flags that mirror the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Latched operands, sticky error, accumulator, status byte and read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            scal_q   <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            lastc_q  <= '0;
            eleout_q <= '0;
        end else begin
            if (accept_c) begin
                op_q   <= op;
                scal_q <= eleIn;
                err_q  <= illegal_c;
            end else if (we && busy_q) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_RUN && op_q == OP_MUL) begin
                acc_q <= mac_out_c;
            end
            if (c_wr_c) begin
                lastc_q <= c_val_c[7:0];
            end
            eleout_q <= rd_c;
        end
    end

    // Register banks: A/B written by the host while idle, C only by operations
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                    c_q[r][c] <= '0;
                end
            end
        end else begin
            if (we && !busy_q && rng_c) begin
                if (wbank) begin
                    b_q[row][col] <= eleIn;
                end else begin
                    a_q[row][col] <= eleIn;
                end
            end
            if (c_wr_c) begin
                c_q[i_q][j_q] <= c_val_c;
            end
        end
    end

    // Status display assembled from registered fields
    always_comb begin
        led_c                        = '0;
        led_c[LED_BUSY]              = busy_q;
        led_c[LED_ERR]               = err_q;
        led_c[LED_OP_LSB +: OP_W]    = op_q;
        led_c[LED_C_MSB:0]           = lastc_q;
    end

    assign eleOut = eleout_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign LED    = led_c;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Self-checking bench for matrix_alu_seq (N=3, W=32) against a behavioural matrix model.
module tb_matrix_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        we;
    logic        wbank;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [31:0] eleIn;
    logic [1:0]  rbank;
    logic [31:0] eleOut;
    logic        busy;
    logic        done;
    logic [15:0] LED;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [31:0] ma [3][3];
    logic [31:0] mb [3][3];
    logic [31:0] mc [3][3];

    matrix_alu_seq #(.N(3), .W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .we     (we),
        .wbank  (wbank),
        .row    (row),
        .col    (col),
        .eleIn  (eleIn),
        .rbank  (rbank),
        .eleOut (eleOut),
        .busy   (busy),
        .done   (done),
        .LED    (LED)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: whole-matrix results from the operation definitions
    task automatic model_exec(input logic [2:0] o, input logic [31:0] s);
        logic [31:0] sum;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                case (o)
                    3'd0: mc[i][j] = ma[i][j] + mb[i][j];
                    3'd1: mc[i][j] = ma[i][j] - mb[i][j];
                    3'd2: mc[i][j] = ma[i][j] * mb[i][j];
                    3'd3: begin
                        sum = 32'd0;
                        for (int k = 0; k < 3; k++) sum = sum + ma[i][k] * mb[k][j];
                        mc[i][j] = sum;
                    end
                    3'd4: mc[i][j] = ma[j][i];
                    3'd5: mc[i][j] = s * ma[i][j];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic write_elem(input logic b, input logic [1:0] r, input logic [1:0] c,
                              input logic [31:0] v);
        @(negedge clk);
        we = 1'b1; wbank = b; row = r; col = c; eleIn = v;
        @(negedge clk);
        we = 1'b0;
        if (r < 2'd3 && c < 2'd3) begin
            if (b) mb[r][c] = v;
            else   ma[r][c] = v;
        end
    endtask

    task automatic read_elem(input logic [1:0] b, input logic [1:0] r, input logic [1:0] c,
                             output logic [31:0] v);
        @(negedge clk);
        rbank = b; row = r; col = c;
        @(negedge clk);
        v = eleOut;
    endtask

    task automatic check_c();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                read_elem(2'd2, 2'(i), 2'(j), v);
                check($sformatf("C[%0d][%0d]", i, j), v, mc[i][j]);
            end
        end
    endtask

    // Issue an op, optionally disturb it mid-run, count busy cycles and check the done pulse
    task automatic run_op(input logic [2:0] o, input logic [31:0] s, input bit chg,
                          input bit bwr, input bit bst, output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; eleIn = s;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (chg && cyc == 3) eleIn = 32'd5;
            if (bwr && cyc == 2) begin
                we = 1'b1; wbank = 1'b0; row = 2'd0; col = 2'd0; eleIn = 32'hDEAD;
            end
            if (bst && cyc == 4) begin
                start = 1'b1; op = 3'd3;
            end
            @(negedge clk);
            we = 1'b0;
            start = 1'b0;
        end
        check("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("done_fall", 32'(done), 32'd0);
    endtask

    function automatic logic [31:0] exp_led(input logic e, input logic [2:0] o);
        return {16'd0, 1'b0, e, o, 3'b000, mc[2][2][7:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [2:0]  o;
        logic [31:0] s;
        int          cyc;
        int          dcnt;

        reset = 1'b1; start = 1'b0; op = 3'd0; we = 1'b0; wbank = 1'b0;
        row = 2'd0; col = 2'd0; eleIn = 32'd0; rbank = 2'd0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = 32'd0; mb[i][j] = 32'd0; mc[i][j] = 32'd0;
            end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_eleOut", eleOut, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_led", 32'(LED), 32'd0);
        reset = 1'b0;
        read_elem(2'd2, 2'd1, 2'd1, v);
        check("rst_c11", v, 32'd0);

        // Directed ADD
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                write_elem(1'b0, 2'(i), 2'(j), 32'(i * 3 + j));
                write_elem(1'b1, 2'(i), 2'(j), 32'd10);
            end
        run_op(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, cyc);
        model_exec(3'd0, 32'd0);
        check("add_cycles", 32'(cyc), 32'd9);
        check("add_led", 32'(LED), exp_led(1'b0, 3'd0));
        check("add_led_low", 32'(LED[7:0]), 32'h12);
        read_elem(2'd2, 2'd2, 2'd2, v);
        check("add_c22", v, 32'd18);
        check_c();

        // Directed MUL
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                write_elem(1'b0, 2'(i), 2'(j), (i == j) ? 32'd2 : 32'd0);
                write_elem(1'b1, 2'(i), 2'(j), 32'(i + j));
            end
        run_op(3'd3, 32'd0, 1'b0, 1'b0, 1'b0, cyc);
        model_exec(3'd3, 32'd0);
        check("mul_cycles", 32'(cyc), 32'd27);
        read_elem(2'd2, 2'd1, 2'd2, v);
        check("mul_c12", v, 32'd6);
        read_elem(2'd2, 2'd0, 2'd0, v);
        check("mul_c00", v, 32'd0);
        check_c();

        // Wrap-around addition
        write_elem(1'b0, 2'd0, 2'd0, 32'h7FFF_FFFF);
        write_elem(1'b1, 2'd0, 2'd0, 32'd1);
        run_op(3'd0, 32'd0, 1'b0, 1'b0, 1'b0, cyc);
        model_exec(3'd0, 32'd0);
        read_elem(2'd2, 2'd0, 2'd0, v);
        check("wrap_c00", v, 32'h8000_0000);
        check("wrap_err", 32'(LED[14]), 32'd0);

        // SCALE with scalar changed mid-run
        write_elem(1'b0, 2'd1, 2'd0, 32'd4);
        run_op(3'd5, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, cyc);
        model_exec(3'd5, 32'hFFFF_FFFD);
        check("scale_cycles", 32'(cyc), 32'd9);
        read_elem(2'd2, 2'd1, 2'd0, v);
        check("scale_c10", v, 32'hFFFF_FFF4);
        check_c();

        // Write and start while busy are ignored; the write flags err
        run_op(3'd0, 32'd0, 1'b0, 1'b1, 1'b1, cyc);
        model_exec(3'd0, 32'd0);
        check("busy_cycles", 32'(cyc), 32'd9);
        check("busy_led", 32'(LED), exp_led(1'b1, 3'd0));
        read_elem(2'd0, 2'd0, 2'd0, v);
        check("busy_a00", v, ma[0][0]);
        check_c();

        // Illegal op goes straight to DONE and leaves C untouched
        @(negedge clk);
        start = 1'b1; op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_done", 32'(done), 32'd1);
        @(negedge clk);
        check("ill_done_fall", 32'(done), 32'd0);
        check("ill_led", 32'(LED), exp_led(1'b1, 3'd7));
        check_c();

        // Randomized operations
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    write_elem(1'b0, 2'(i), 2'(j), $urandom);
                    write_elem(1'b1, 2'(i), 2'(j), $urandom);
                end
            o = 3'($urandom_range(0, 5));
            s = $urandom;
            run_op(o, s, 1'b0, 1'b0, 1'b0, cyc);
            model_exec(o, s);
            check($sformatf("rnd%0d_cycles", it), 32'(cyc), (o == 3'd3) ? 32'd27 : 32'd9);
            check($sformatf("rnd%0d_led", it), 32'(LED), exp_led(1'b0, o));
            check_c();
        end

        // Out-of-range writes and reads
        write_elem(1'b0, 2'd3, 2'd0, 32'h1234_5678);
        check("oor_err", 32'(LED[14]), 32'd0);
        read_elem(2'd0, 2'd3, 2'd0, v);
        check("oor_read", v, 32'd0);
        read_elem(2'd3, 2'd1, 2'd1, v);
        check("rbank3_read", v, 32'd0);
        read_elem(2'd0, 2'd1, 2'd1, v);
        check("a11_read", v, ma[1][1]);

        // Reset in the middle of MUL
        @(negedge clk);
        start = 1'b1; op = 3'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 10) begin
            cyc++;
            if (cyc < 10) @(negedge clk);
        end
        check("mulrst_reached", 32'(cyc), 32'd10);
        reset = 1'b1;
        @(negedge clk);
        check("mulrst_busy", 32'(busy), 32'd0);
        check("mulrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = 32'd0; mb[i][j] = 32'd0; mc[i][j] = 32'd0;
            end
        dcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("mulrst_no_done", 32'(dcnt), 32'd0);
        read_elem(2'd2, 2'd0, 2'd0, v);
        check("mulrst_c00", v, 32'd0);
        check("mulrst_led", 32'(LED), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/matrix_alu_seq.md
MATRIX_ALU_SEQ -- requirements
Module: matrix_alu_seq

Interface
REQ-001 Parameters SHALL be:
- N, default 3: matrix dimension (N x N), legal range 2..8.
- W, default 32: element width in bits, signed two's complement.
- AW, default $clog2(N), minimum 1: row/column index width.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle operation request.
- op  in  3  operation code.
- we  in  1  element write strobe.
- wbank  in  1  write target: 0=A, 1=B.
- row  in  AW  element row index (write and read).
- col  in  AW  element column index (write and read).
- eleIn  in  W  write data; also the scalar operand for SCALE.
- rbank  in  2  read source: 0=A, 1=B, 2=C, 3=reserved.
- eleOut  out  W  registered read data.
- busy  out  1  high while an operation executes.
- done  out  1  one-cycle completion pulse.
- LED  out  16  status display.

Function
REQ-003 Three NxN register banks A, B, C SHALL hold W-bit elements; C SHALL be written only by operations.
REQ-004 When we=1, busy=0, row<N and col<N, bank[wbank][row][col] SHALL take eleIn at the clock edge.
REQ-005 A write with busy=1 SHALL be ignored and SHALL set the sticky err flag; a write with an out-of-range index SHALL be ignored without setting err.
REQ-006 eleOut SHALL equal bank[rbank][row][col] one cycle after the address is presented; for rbank=3 or an out-of-range index it SHALL be 0.
REQ-007 Op codes SHALL be: 0 ADD C=A+B; 1 SUB C=A-B; 2 HAD C[i][j]=A[i][j]*B[i][j]; 3 MUL C=A x B (matrix product); 4 TRN C=A transposed; 5 SCALE C=eleIn*A.
REQ-008 Results SHALL be truncated modulo 2^W with no saturation; the MUL accumulator SHALL be W bits wide and wrap.
REQ-009 The FSM states SHALL be IDLE, RUN and DONE.
REQ-010 FSM transitions:
- IDLE to RUN on start=1 with a legal op.
- RUN to DONE after the last element is written.
- DONE to IDLE unconditionally.
REQ-011 On start, op SHALL be latched; for SCALE, eleIn SHALL also be latched, and later changes to eleIn SHALL not affect the result.
REQ-012 In RUN, the element-wise ops (0,1,2,4,5) SHALL write one C element per cycle in row-major order (i outer, j inner), taking N*N cycles.
REQ-013 In RUN, MUL SHALL perform one multiply-accumulate per cycle (k innermost) and write C[i][j] on the cycle k=N-1, taking N*N*N cycles.
REQ-014 busy SHALL be high exactly in the RUN state; done SHALL be high exactly in the DONE state.
REQ-015 start while busy or in DONE SHALL be ignored; start in IDLE with op 6 or 7 SHALL go directly to DONE, set err, and leave C unchanged.
REQ-016 Each start accepted from IDLE SHALL clear err, except an illegal op, which sets it.
REQ-017 LED SHALL show:
- [15] busy.
- [14] err.
- [13:11] last latched op.
- [10:8] zero.
- [7:0] low 8 bits of the most recent C element written.

Reset
REQ-018 On reset=1, asynchronously:
- all elements of A, B and C SHALL be 0;
- the FSM SHALL be in IDLE;
- the counters, accumulator and err SHALL be 0;
- eleOut, busy, done and LED SHALL be 0.
REQ-019 Reset during RUN SHALL abort the operation immediately, with no done pulse.

Structure
REQ-020 A shared package matrix_alu_pkg SHALL hold the op-code constants, the state enum, and the LED bit-field positions.
REQ-021 The multiply-accumulate datapath SHALL be a sub-module matrix_alu_mac, parametrised by W, with inputs a, b, acc_in and clear, and output acc_out.

Verification
REQ-022 The bench SHALL cover these directed scenarios with N=3, W=32:
- ADD: A[i][j]=i*3+j, B all 10, start op=0 -> busy for 9 cycles, done 1 cycle, C[2][2]=18, LED[7:0]=0x12.
- MUL: A = identity*2, B[i][j]=i+j, start op=3 -> busy for 27 cycles, then C[1][2]=6 and C[0][0]=0.
- Wrap: A[0][0]=0x7FFFFFFF, B[0][0]=1, op=0 -> C[0][0]=0x80000000, err=0.
- SCALE: latch eleIn=-3 at start, then change eleIn to 5 mid-run; with A[1][0]=4 -> C[1][0]=-12.
- Illegal cases:
  - write during busy -> bank unchanged, LED[14]=1;
  - op=7 -> done next cycle, C unchanged, err=1;
  - start during RUN -> ignored.
- Reset mid-MUL at cycle 10 -> next cycle busy=0, done never pulses, reading C[0][0] returns 0.
